// File: rtl/fsm_pkg.sv
// Shared constants for the control FSM and its input conditioner.
// The FSM top-level integration picks up the same debounce defaults from here.
package fsm_pkg;

  localparam int DB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF     = 3;

  // Per-channel conditioned view handed to the FSM.
  typedef struct packed {
    logic level;
    logic rise;
  } cond_t;

endpackage

// File: rtl/debounce_ch.sv
// One conditioned input channel: two-flop synchroniser, debounce counter,
// registered clean level and a one-cycle pulse on each accepted 0->1.
module debounce_ch
  import fsm_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic settled
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // s2 has differed from level for DB_CYCLES consecutive cycles.
  assign accept  = (s2 != level) && (cnt == CNT_LAST);
  assign settled = (s2 == level);

  // NOTE: every register here uses <= so s2 reads the old s1 and the counter,
  // level and rise all see the same pre-edge values; blocking '=' would
  // collapse the synchroniser into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= accept && s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fsm_in_cond.sv
// Input conditioner for the control FSM: two independent debounced channels
// plus a combined flag that is high while neither channel has a pending change.
module fsm_in_cond
  import fsm_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise,
  output logic stable
);

  cond_t ch_a;
  cond_t ch_b;
  logic  settled_a;
  logic  settled_b;

  debounce_ch #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_ch_a (
    .clk    (clk),
    .rst    (rst),
    .raw    (a_raw),
    .level  (ch_a.level),
    .rise   (ch_a.rise),
    .settled(settled_a)
  );

  debounce_ch #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_ch_b (
    .clk    (clk),
    .rst    (rst),
    .raw    (b_raw),
    .level  (ch_b.level),
    .rise   (ch_b.rise),
    .settled(settled_b)
  );

  assign a      = ch_a.level;
  assign b      = ch_b.level;
  assign a_rise = ch_a.rise;
  assign b_rise = ch_b.rise;
  assign stable = settled_a && settled_b;

endmodule

// File: tb/tb_fsm_in_cond.sv
// Scoreboard bench for fsm_in_cond: directed raw-input sequences push the
// hand-derived output changes they cause; monitors pop one entry per change.
module tb_fsm_in_cond;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic a_raw  = 1'b1;
  logic b_raw  = 1'b1;
  logic a1_raw = 1'b0;
  logic b1_raw = 1'b0;

  logic a, b, a_rise, b_rise, stable;
  logic a1, b1, a1_rise, b1_rise, stable1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [4:0] vec;   // {a, b, a_rise, b_rise, stable}
  } ev_t;

  ev_t q4[$];
  ev_t q1[$];

  fsm_in_cond #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a),
    .b     (b),
    .a_rise(a_rise),
    .b_rise(b_rise),
    .stable(stable)
  );

  fsm_in_cond #(.DB_CYCLES(1), .CNT_W(3)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .a_raw (a1_raw),
    .b_raw (b1_raw),
    .a     (a1),
    .b     (b1),
    .a_rise(a1_rise),
    .b_rise(b1_rise),
    .stable(stable1)
  );

  always #5 clk = ~clk;

  // cyc == k at the negedge following the k-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void exp4(input int c, input logic [4:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    q4.push_back(e);
  endfunction

  function automatic void exp1(input int c, input logic [4:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    q1.push_back(e);
  endfunction

  // Return so that the next rising edge is edge n.
  task automatic at_edge(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  logic [4:0] prev4 = 'x;
  logic [4:0] prev1 = 'x;

  always @(negedge clk) begin
    logic [4:0] v;
    ev_t        e;
    v = {a, b, a_rise, b_rise, stable};
    if (v !== prev4) begin
      if (q4.size() == 0) begin
        check("db4 unexpected change", int'(v), int'(prev4));
      end else begin
        e = q4.pop_front();
        check("db4 event cycle", cyc, e.cyc);
        check("db4 event outputs", int'(v), int'(e.vec));
      end
      prev4 = v;
    end
  end

  always @(negedge clk) begin
    logic [4:0] v;
    ev_t        e;
    v = {a1, b1, a1_rise, b1_rise, stable1};
    if (v !== prev1) begin
      if (q1.size() == 0) begin
        check("db1 unexpected change", int'(v), int'(prev1));
      end else begin
        e = q1.pop_front();
        check("db1 event cycle", cyc, e.cyc);
        check("db1 event outputs", int'(v), int'(e.vec));
      end
      prev1 = v;
    end
  end

  initial begin
    // Reset held over edges 1-2 with raw lines high: outputs stay 0.
    exp4(1, 5'b00001);
    exp1(1, 5'b00001);

    // Release: raw first sampled at edge 3, levels and pulses after edge 8.
    at_edge(3);
    rst = 1'b0;
    exp4(4, 5'b00000);
    exp4(8, 5'b11111);
    exp4(9, 5'b11001);

    // Both lines drop together.
    at_edge(12);
    a_raw = 1'b0;
    b_raw = 1'b0;
    exp4(13, 5'b11000);
    exp4(17, 5'b00001);

    // Clean rise on A only; DB=1 instance rises on A as well.
    at_edge(20);
    a_raw  = 1'b1;
    a1_raw = 1'b1;
    exp4(21, 5'b00000);
    exp4(25, 5'b10101);
    exp4(26, 5'b10001);
    exp1(21, 5'b00000);
    exp1(22, 5'b10101);
    exp1(23, 5'b10001);

    // Falling bounce on A: low 2, high 1, then low for good.
    at_edge(30);
    a_raw  = 1'b0;
    a1_raw = 1'b0;
    exp4(31, 5'b10000);
    exp4(33, 5'b10001);
    exp4(34, 5'b10000);
    exp4(38, 5'b00001);
    exp1(31, 5'b10000);
    exp1(32, 5'b00001);
    at_edge(32);
    a_raw = 1'b1;
    at_edge(33);
    a_raw = 1'b0;

    // DB=1: a single-cycle pulse on B is accepted and then released.
    at_edge(40);
    b1_raw = 1'b1;
    exp1(41, 5'b00000);
    exp1(42, 5'b01010);
    exp1(43, 5'b00001);
    at_edge(41);
    b1_raw = 1'b0;

    // Glitch on A for 3 cycles: never accepted.
    at_edge(42);
    a_raw = 1'b1;
    exp4(43, 5'b00000);
    exp4(46, 5'b00001);
    at_edge(45);
    a_raw = 1'b0;

    // Simultaneous rise on both channels.
    at_edge(50);
    a_raw = 1'b1;
    b_raw = 1'b1;
    exp4(51, 5'b00000);
    exp4(55, 5'b11111);
    exp4(56, 5'b11001);

    at_edge(60);
    a_raw = 1'b0;
    b_raw = 1'b0;
    exp4(61, 5'b11000);
    exp4(65, 5'b00001);

    // Reset on the second count cycle discards the count.
    at_edge(70);
    a_raw = 1'b1;
    exp4(71, 5'b00000);
    at_edge(73);
    rst = 1'b1;
    exp4(73, 5'b00001);
    exp4(75, 5'b00000);
    exp4(79, 5'b10101);
    at_edge(74);
    rst = 1'b0;

    // Reset while a_rise is high cancels the pulse and the level.
    at_edge(80);
    rst = 1'b1;
    exp4(80, 5'b00001);
    exp4(82, 5'b00000);
    exp4(86, 5'b10101);
    exp4(87, 5'b10001);
    at_edge(81);
    rst = 1'b0;

    at_edge(95);
    @(negedge clk);
    check("db4 events still pending", q4.size(), 0);
    check("db1 events still pending", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_in_cond.md
Name: fsm_in_cond

Overview:
Input conditioner that sits directly upstream of the control FSM and drives its a/b inputs. It takes two asynchronous raw lines (a_raw, b_raw), such as buttons or external strobes. For each line it synchronises, debounces and produces:
- a clean level,
- a single-cycle rising-edge pulse.

A "stable" flag reports when neither channel has a pending transition. The FSM consumes a/b levels directly.

Parameters:
DB_CYCLES, 4, consecutive synchronised cycles a new value must persist before it is accepted (legal range 1..2**CNT_W-1)
CNT_W, 3, width of each debounce counter

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset; priority over all other logic
a_raw  in  1  asynchronous raw input, channel A
b_raw  in  1  asynchronous raw input, channel B
a  out  1  debounced level, channel A (to FSM input a)
b  out  1  debounced level, channel B (to FSM input b)
a_rise  out  1  one-cycle pulse on accepted 0->1 of a
b_rise  out  1  one-cycle pulse on accepted 0->1 of b
stable  out  1  1 when both synchronised inputs equal their debounced levels

Behaviour:
- Reset: the reset condition is rst=1 sampled at a clk edge. The following all become 0:
  - both sync flops per channel,
  - both counters,
  - a, b, a_rise, b_rise.
- After reset, stable=1 only if the synchronised inputs are 0.
- Synchroniser: two flops per channel (s1 <= raw; s2 <= s1). No logic between the flops.
- Debounce, per channel, with deb being the registered level output:
  - s2 == deb -> cnt <= 0. Any glitch shorter than DB_CYCLES restarts the count.
  - s2 != deb and cnt != DB_CYCLES-1 -> cnt <= cnt+1.
  - s2 != deb and cnt == DB_CYCLES-1 -> deb <= s2, cnt <= 0.
- Latency: raw first sampled high at edge N and held -> a=1 after edge N+DB_CYCLES+1. With the default of 4 this is edge N+5. Falling transitions have identical latency.
- Rise pulse: registered. a_rise=1 in exactly the cycle where a first reads 1. It returns to 0 at the next edge, even if a stays 1. There is no pulse on a falling transition.
- stable: combinational, (s2_a == a) && (s2_b == b).
- Channels are fully independent. If a_raw and b_raw change at the same edge, a and b update at the same edge. This lets the FSM see a&b in one cycle.
- DB_CYCLES=1: a change is accepted one edge after it reaches s2.
- Counter never exceeds DB_CYCLES-1. No wrap-around is possible within the legal range.
- Reset mid-count: count discarded, outputs 0 after the reset edge. A pending rise pulse is cancelled.
- Raw toggling continuously faster than DB_CYCLES: deb holds its value indefinitely and stable toggles.

Decomposition:
- Shared package fsm_pkg: default DB_CYCLES/CNT_W constants, reused by the FSM top-level integration.
- One sub-module, debounce_ch, instantiated twice. It contains:
  - sync flops, counter, deb register, rise register;
  - ports clk, rst, raw, level, rise, settled.
- The top ANDs the two settled signals to form stable.

Test Plan:
1. Reset: rst=1 for 2 cycles with a_raw=b_raw=1 -> a=b=a_rise=b_rise=0 during reset. After release, a rises at release edge+DB_CYCLES+2 (edge+6 for the default).
2. Clean rise, DB=4: a_raw 0->1 sampled at edge 10, held -> a=1 after edge 15, a_rise=1 only in cycle 15-16, b stays 0.
3. Glitch: a_raw high for 3 cycles then low, with DB=4 -> a and a_rise never assert; stable=0 during the glitch, then 1 again.
4. Simultaneous: a_raw and b_raw rise at the same edge 20 -> a, b, a_rise and b_rise all assert after edge 25 in the same cycle.
5. Fall and bounce: a=1, a_raw drops for 2 cycles, rises for 1, then stays low -> a falls 4 cycles after the final drop reaches s2; no a_rise.
6. Reset mid-count: a_raw rises, rst=1 at the 2nd count cycle -> counter=0, a=0 after the reset edge. After release, the full DB_CYCLES+2 latency is observed again.
